// File: rtl/div_recombine8.sv
// Rebuilds a dividend P = Q*B + R by shift-add, one multiplier bit per cycle.
// Shares the start/done/err handshake of the 8-bit restoring divider.
module div_recombine8 #(
  parameter int unsigned W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     Q,
  input  logic [W-1:0]     B,
  input  logic [W-1:0]     R,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             ovf8,
  output logic [2*W-1:0]   P
);

  localparam int unsigned CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_t;

  state_t         state;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] mcand;
  logic [2*W-1:0] acc_nxt;
  logic [W-1:0]   mplr;
  logic [CW-1:0]  cnt;

  // Next accumulator value; also feeds P on the final iteration.
  always_comb begin
    acc_nxt = acc;
    if (mplr[0]) begin
      acc_nxt = acc + mcand;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      ovf8  <= 1'b0;
      P     <= '0;
      acc   <= '0;
      mcand <= '0;
      mplr  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (B == '0 || R >= B) begin
              err   <= 1'b1;
              P     <= '0;
              ovf8  <= 1'b0;
              done  <= 1'b1;
              state <= FIN;
            end else begin
              err   <= 1'b0;
              acc   <= {{W{1'b0}}, R};
              mcand <= {{W{1'b0}}, Q};
              mplr  <= B;
              cnt   <= CW'(W);
              busy  <= 1'b1;
              state <= CALC;
            end
          end
        end
        CALC: begin
          acc   <= acc_nxt;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            P     <= acc_nxt;
            ovf8  <= |acc_nxt[2*W-1:W];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_recombine8.sv
// Randomized bench for div_recombine8 against an arithmetic model of P = Q*B + R.
module tb_div_recombine8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  Q;
  logic [7:0]  B;
  logic [7:0]  R;
  logic        busy;
  logic        done;
  logic        err;
  logic        ovf8;
  logic [15:0] P;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  div_recombine8 #(.W(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .Q     (Q),
    .B     (B),
    .R     (R),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .ovf8  (ovf8),
    .P     (P)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Issues one operation, waits for done (bounded) and compares against
  // the arithmetic model. Inputs change at negedge, outputs sampled there too.
  task automatic run_op(input string tag, input int unsigned q, input int unsigned b,
                        input int unsigned r, input bit scramble, input bit hold,
                        input bit full);
    int unsigned exp_p;
    bit          exp_err;
    int unsigned lat;
    int unsigned busy_cnt;
    exp_err  = (b == 0) || (r >= b);
    exp_p    = exp_err ? 0 : q * b + r;
    lat      = 1;
    busy_cnt = 0;
    @(negedge clk);
    Q = 8'(q); B = 8'(b); R = 8'(r); start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    if (scramble) begin
      Q = 8'($urandom); B = 8'($urandom); R = 8'($urandom);
    end
    while (!done && lat < 40) begin
      busy_cnt += busy;
      @(negedge clk);
      lat++;
    end
    if (lat >= 40) begin
      check({tag, "_timeout"}, lat, 0);
    end else begin
      check({tag, "_P"}, P, exp_p);
      check({tag, "_err"}, err, exp_err);
      check({tag, "_ovf8"}, ovf8, (exp_p >= 256) ? 1 : 0);
      if (full) begin
        check({tag, "_busy"}, busy, 0);
        check({tag, "_busycycles"}, busy_cnt, exp_err ? 0 : 8);
        if (exp_err) check({tag, "_lat_le2"}, (lat >= 1 && lat <= 2) ? 1 : 0, 1);
        else         check({tag, "_lat"}, lat, 9);
      end
    end
    if (hold) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    check({tag, "_donepulse"}, done, 0);
  endtask

  // Confirms nothing new starts and the held result stays put.
  task automatic expect_quiet(input string tag, input int unsigned cycles,
                              input int unsigned exp_p);
    int unsigned seen_done;
    int unsigned seen_busy;
    seen_done = 0;
    seen_busy = 0;
    for (int i = 0; i < int'(cycles); i++) begin
      @(negedge clk);
      seen_done += done;
      seen_busy += busy;
    end
    check({tag, "_nodone"}, seen_done, 0);
    check({tag, "_nobusy"}, seen_busy, 0);
    check({tag, "_Pheld"}, P, exp_p);
  endtask

  initial begin
    int unsigned a, b, q, r;
    rst = 1'b1; start = 1'b0; Q = '0; B = '0; R = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_ovf8", ovf8, 0);
    check("rst_P", P, 0);
    rst = 1'b0;

    run_op("basic", 13, 7, 5, 0, 0, 1);
    expect_quiet("basic_hold", 5, 96);
    run_op("maxval", 255, 255, 254, 0, 0, 1);
    check("maxval_P_hex", P, 16'hFEFF);
    run_op("qzero", 0, 9, 3, 0, 0, 1);
    run_op("b1", 200, 1, 0, 0, 0, 1);
    run_op("b1_bad", 5, 1, 1, 0, 0, 1);
    run_op("bzero", 4, 0, 0, 0, 0, 1);
    run_op("r_eq_b", 3, 7, 7, 0, 0, 1);
    run_op("valid_clr", 10, 10, 9, 0, 0, 1);

    // Start held across CALC and FIN: exactly one completion.
    run_op("held", 21, 11, 4, 0, 1, 1);
    expect_quiet("held_once", 12, 21 * 11 + 4);
    run_op("scram", 99, 123, 45, 1, 0, 1);
    run_op("after_held", 2, 3, 1, 0, 0, 1);

    // Reset during the 4th CALC cycle.
    @(negedge clk);
    Q = 8'd77; B = 8'd55; R = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_busy_pre", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_err", err, 0);
    check("midrst_P", P, 0);
    check("midrst_ovf8", ovf8, 0);

    // rst and start together: nothing accepted.
    run_op("pre_rs", 0, 0, 0, 0, 0, 0);
    check("pre_rs_err", err, 1);
    Q = 8'd9; B = 8'd8; R = 8'd1; rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rs_err", err, 0);
    expect_quiet("rs", 12, 0);

    for (int i = 0; i < 400; i++) begin
      run_op("rand", $urandom_range(0, 255), $urandom_range(0, 255),
             $urandom_range(0, 255), i[0], 0, i < 20);
    end

    // Round trip through the divider's outputs: A -> (A/B, A%B) -> A.
    for (int i = 0; i < 3000; i++) begin
      a = $urandom_range(0, 255);
      b = (i < 256) ? 1 + (i % 255) : $urandom_range(1, 255);
      if (i < 256) a = 255 - i;
      q = a / b;
      r = a % b;
      run_op("trip", q, b, r, 0, 0, 0);
      check("trip_A", P, a);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
